// File: rtl/rr_arbiter16_pkg.sv
// rtl/rr_arbiter16_pkg.sv - shared arbiter state encodings and width helper
package rr_arbiter16_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2_f(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter16_pick.sv
// rtl/rr_arbiter16_pick.sv - combinational rotate-and-priority-encode from a start pointer
module rr_pick
    import rr_arbiter16_pkg::*;
#(
    parameter int N    = 16,
    parameter int IDXW = 4
) (
    input  logic [N-1:0]    vector,
    input  logic [IDXW-1:0] ptr,
    input  logic [IDXW-1:0] mask_idx,
    input  logic            mask_en,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [N-1:0] masked;
    int           cand;

    always_comb begin
        masked = vector;
        for (int i = 0; i < N; i++) begin
            if (mask_en && (int'(mask_idx) == i)) begin
                masked[i] = 1'b0;
            end
        end
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        // Scan ptr, ptr+1, ... wrapping modulo N; first hit wins.
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && masked[cand]) begin
                found = 1'b1;
                idx   = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// rtl/rr_arbiter16.sv - registered round-robin arbiter with held grant and rotating pointer
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int N    = 16,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            grant_ack,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic [N-1:0]    grant_onehot,
    output logic [IDXW-1:0] ptr_dbg
);

    arb_state_e      state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] next_ptr;
    logic [IDXW-1:0] pick_ptr;
    logic            acked;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic [N-1:0]    pick_onehot;

    assign acked       = (state == ARB_GRANT) && grant_ack;
    assign next_ptr    = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + 1'b1;
    // On ack, arbitrate against the advanced pointer so the next grant has no bubble.
    assign pick_ptr    = acked ? next_ptr : ptr;
    assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    assign ptr_dbg     = ptr;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .vector   (req),
        .ptr      (pick_ptr),
        .mask_idx (grant_idx),
        .mask_en  (acked),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            ptr          <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state        <= ARB_GRANT;
                        grant_valid  <= 1'b1;
                        grant_idx    <= pick_idx;
                        grant_onehot <= pick_onehot;
                    end
                end
                ARB_GRANT: begin
                    if (grant_ack) begin
                        ptr <= next_ptr;
                        if (pick_found) begin
                            grant_idx    <= pick_idx;
                            grant_onehot <= pick_onehot;
                        end else begin
                            state        <= ARB_IDLE;
                            grant_valid  <= 1'b0;
                            grant_idx    <= '0;
                            grant_onehot <= '0;
                        end
                    end else if (!req[grant_idx]) begin
                        // Withdrawn request revokes the grant; pointer stays put.
                        state        <= ARB_IDLE;
                        grant_valid  <= 1'b0;
                        grant_idx    <= '0;
                        grant_onehot <= '0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb/tb_rr_arbiter16.sv - directed vector bench for rr_arbiter16
module tb_rr_arbiter16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        grant_ack;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic [3:0]  ptr_dbg;

    int passed;
    int total;

    typedef struct {
        logic        r;
        logic [15:0] q;
        logic        a;
        logic        v;
        logic [3:0]  i;
        logic [3:0]  p;
    } vec_t;

    vec_t tbl [10];

    rr_arbiter16 #(.N(16), .IDXW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant_ack    (grant_ack),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .ptr_dbg      (ptr_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        if (got === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input string name, input logic r, input logic [15:0] q, input logic a,
                         input logic ev, input logic [3:0] ei, input logic [3:0] ep);
        logic [15:0] eoh;
        rst       = r;
        req       = q;
        grant_ack = a;
        @(posedge clk);
        #1;
        eoh = ev ? (16'h0001 << ei) : 16'h0000;
        check({name, ".valid"},  {15'd0, grant_valid}, {15'd0, ev});
        check({name, ".idx"},    {12'd0, grant_idx},   {12'd0, ei});
        check({name, ".onehot"}, grant_onehot,         eoh);
        check({name, ".ptr"},    {12'd0, ptr_dbg},     {12'd0, ep});
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        req       = 16'h0000;
        grant_ack = 1'b0;

        //           rst   req        ack   valid idx    ptr
        tbl[0] = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[6] = '{1'b0, 16'h0028, 1'b1, 1'b1, 4'd3, 4'd0};
        tbl[7] = '{1'b0, 16'h0028, 1'b1, 1'b1, 4'd5, 4'd4};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd6};
        tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd6};

        for (int n = 0; n < 10; n++) begin
            apply($sformatf("vec%0d", n), tbl[n].r, tbl[n].q, tbl[n].a,
                  tbl[n].v, tbl[n].i, tbl[n].p);
        end

        // Full request load: strict rotation 0..15 then wrap to 0.
        apply("all_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0);
        apply("all_g0", 1'b0, 16'hFFFF, 1'b1, 1'b1, 4'd0, 4'd0);
        for (int k = 1; k < 16; k++) begin
            apply($sformatf("all_g%0d", k), 1'b0, 16'hFFFF, 1'b1, 1'b1, 4'(k), 4'(k));
        end
        apply("all_wrap", 1'b0, 16'hFFFF, 1'b1, 1'b1, 4'd0, 4'd0);

        // Hold grant 7 against a higher-priority newcomer, then ack.
        apply("hold_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0);
        apply("hold_g7", 1'b0, 16'h0080, 1'b0, 1'b1, 4'd7, 4'd0);
        for (int k = 0; k < 10; k++) begin
            apply($sformatf("hold%0d", k), 1'b0, 16'h0084, 1'b0, 1'b1, 4'd7, 4'd0);
        end
        apply("hold_ack7", 1'b0, 16'h0084, 1'b1, 1'b1, 4'd2, 4'd8);
        apply("hold_ack2", 1'b0, 16'h0004, 1'b1, 1'b0, 4'd0, 4'd3);

        // Withdrawal without ack revokes, pointer unchanged.
        apply("wd_g4",   1'b0, 16'h0010, 1'b0, 1'b1, 4'd4, 4'd3);
        apply("wd_drop", 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd3);
        apply("wd_g9",   1'b0, 16'h0200, 1'b0, 1'b1, 4'd9, 4'd3);

        // Reset wins over ack on grant 12.
        apply("rs_g12",  1'b0, 16'h1000, 1'b1, 1'b1, 4'd12, 4'd10);
        apply("rs_rst",  1'b1, 16'h1000, 1'b1, 1'b0, 4'd0,  4'd0);
        apply("rs_g12b", 1'b0, 16'h1000, 1'b0, 1'b1, 4'd12, 4'd0);

        // Ack coinciding with withdrawal is an ack: pointer advances.
        apply("ackwd",   1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  4'd13);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Registered round-robin arbiter over up to 16 single-bit requesters.
- Produces a 4-bit grant index that drives the select input of the downstream 16:1 single-bit mux; the mux picks the granted requester's status bit.
- Grant is held stable until the consumer acknowledges. The rotating priority pointer guarantees starvation freedom.

Parameters:
- N, 16, number of requesters; legal range 2..16.
- IDXW, 4, index width; must be at least clog2(N). Upper index bits are driven 0 when N < 16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector; bit i = requester i wants service
- grant_ack  input  1  consumer accepted the current grant; ignored unless grant_valid=1
- grant_valid  output  1  grant_idx/grant_onehot are meaningful
- grant_idx  output  IDXW  winning requester index; feeds the downstream mux select
- grant_onehot  output  N  one-hot form of grant_idx; all zero when grant_valid=0
- ptr_dbg  output  IDXW  current priority pointer (highest-priority index), for verification

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. All outputs are registered.
- Reset: state=IDLE, ptr=0, grant_valid=0, grant_idx=0, grant_onehot=0.
- Winner function: the first set bit of the masked request vector, scanning ptr, ptr+1, … N-1, 0, … ptr-1 (wraps modulo N).
- IDLE:
  - If any req bit is set at edge t, grant_valid=1 from t+1 with the winner index, and state becomes GRANT.
  - Latency from request to grant is 1 cycle.
  - If no request is present, remain in IDLE with outputs at 0.
- GRANT with grant_ack=1:
  - ptr <= (grant_idx+1) mod N.
  - Back-to-back arbitration happens in the same cycle, using the new ptr and req with bit grant_idx masked off.
  - If a winner exists, the new grant appears next cycle with no bubble. Otherwise grant_valid drops to 0 and state returns to IDLE.
- GRANT with grant_ack=0 and req[grant_idx]=1: all outputs hold stable. They must not change even if higher-priority requests arrive.
- GRANT with grant_ack=0 and req[grant_idx]=0 (request withdrawn):
  - Grant is revoked: grant_valid=0 next cycle, state IDLE, ptr unchanged.
  - Re-arbitration happens from IDLE on the following edge.
- Simultaneous ack and withdrawal of the granted bit: treated as ack. The withdrawal is irrelevant because that bit is masked.
- Pointer wrap: a grant to index N-1 followed by ack sets ptr=0.
- Reset mid-grant: takes priority over ack. Outputs clear at the reset edge and no pointer update occurs.
- Requests at index ≥ N do not exist; unused upper mux inputs are never selected.
- The grant_onehot bit for grant_idx is always set exactly when grant_valid=1. Invariant: grant_onehot == (grant_valid << grant_idx).

Decomposition:
- Shared package/header: state encodings (ARB_IDLE=1'b0, ARB_GRANT=1'b1) and a clog2 constant function. These are reused by other arbiters in the pipeline.
- One natural sub-module: rr_pick, a combinational rotate-and-priority-encode.
  - Inputs: vector, ptr, mask_idx, mask_en.
  - Outputs: found, idx.
  - rr_arbiter16 holds only the FSM, pointer and output registers.

Test Plan:
- Reset then req=16'h0000 for 5 cycles -> grant_valid=0, grant_idx=0, ptr_dbg=0 throughout.
- From ptr=0, req=16'h0028 (bits 3,5) with ack every cycle -> grants 3 then 5 on consecutive cycles; ptr_dbg=6 after the second ack; grant_valid=0 once req clears.
- All 16 requests held continuously with ack every cycle -> grant_idx sequence 0,1,…,15,0 with no bubbles; after the ack of 15, ptr_dbg=0.
- Granted idx=7 held; req[2] asserted, no ack for 10 cycles -> grant_idx stays 7, grant_onehot=16'h0080; ack -> next grant is idx 2 (after wrap), ptr_dbg=8 then 3.
- Grant idx=4 then req[4] dropped with no ack -> grant_valid=0 next cycle, ptr_dbg unchanged; with req[9]=1 -> grant 9 one cycle later.
- rst asserted in the same cycle as grant_ack on idx=12 -> next cycle all outputs 0 and ptr_dbg=0 (not 13).
